// File: rtl/dircc_fanout_sequencer.sv
// dircc_fanout_sequencer
//
// Fans one send request out to every (port, target) pair it names. A request
// carries a port bitmask, a payload and a lamport stamp. The block walks a
// locally held target table and emits one beat per destination over an
// Avalon-ST style valid/ready interface.
//
// Ports:
//   clk, reset_n       clock and synchronous active-low reset
//   cfg_*              table load: per-port target count and per-target address.
//                      Writes are accepted only while idle.
//   cfg_err            one-cycle pulse when a cfg write was dropped while busy
//   req_*              request handshake (port mask, payload, lamport)
//   out_*              beat stream (dest, source port, payload, lamport, last)
//   busy               a request is in flight
//   done               one-cycle pulse when a request has been fully emitted
//
// MAX_TARGETS is expected to be a power of two, so every cfg_index value
// addresses a real table entry.
module dircc_fanout_sequencer #(
  parameter int NUM_PORTS     = 8,
  parameter int MAX_TARGETS   = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int LAMPORT_WIDTH = 32,
  localparam int PORT_IDX_W   = $clog2(NUM_PORTS),
  localparam int TGT_IDX_W    = $clog2(MAX_TARGETS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_addr_write,
  input  logic                     cfg_count_write,
  input  logic [PORT_IDX_W-1:0]    cfg_port,
  input  logic [TGT_IDX_W-1:0]     cfg_index,
  input  logic [ADDR_WIDTH-1:0]    cfg_dest,
  input  logic [TGT_IDX_W:0]       cfg_count,
  output logic                     cfg_err,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_PORTS-1:0]     req_ports,
  input  logic [DATA_WIDTH-1:0]    req_data,
  input  logic [LAMPORT_WIDTH-1:0] req_lamport,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_dest,
  output logic [PORT_IDX_W-1:0]    out_port,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [LAMPORT_WIDTH-1:0] out_lamport,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = TGT_IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SELECT, EMIT} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_tab [NUM_PORTS][MAX_TARGETS];
  logic [CNT_W-1:0]        count_tab [NUM_PORTS];
  logic [NUM_PORTS-1:0]    pending;
  logic [TGT_IDX_W-1:0]    target;

  logic [NUM_PORTS-1:0]    nz_mask;
  logic [NUM_PORTS-1:0]    live;
  logic                    sel_found;
  logic [PORT_IDX_W-1:0]   sel_port;
  logic [NUM_PORTS-1:0]    sel_onehot;
  logic [NUM_PORTS-1:0]    cur_onehot;
  logic                    others_sel;
  logic                    others_cur;
  logic [CNT_W:0]          cur_cnt;
  logic [CNT_W:0]          tgt_p1;
  logic [CNT_W:0]          tgt_p2;
  logic                    more;
  logic                    fire;
  logic                    cfg_any;
  logic                    cfg_ok;
  logic [CNT_W-1:0]        cfg_count_clamped;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fire      = (state == EMIT) && out_valid && out_ready;
  assign cfg_any   = cfg_addr_write || cfg_count_write;
  assign cfg_ok    = (state == IDLE);

  assign cfg_count_clamped = (cfg_count > CNT_W'(MAX_TARGETS)) ? CNT_W'(MAX_TARGETS) : cfg_count;

  // Port selection: lowest-index pending port whose count is non-zero.
  always_comb begin
    nz_mask   = '0;
    sel_found = 1'b0;
    sel_port  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      nz_mask[i] = (count_tab[i] != '0);
    end
    live = pending & nz_mask;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (live[i]) begin
        sel_found = 1'b1;
        sel_port  = PORT_IDX_W'(i);
      end
    end
    sel_onehot = NUM_PORTS'(1) << sel_port;
    cur_onehot = NUM_PORTS'(1) << out_port;
    // "Others" decide out_last: no other port will contribute a beat.
    others_sel = |(live & ~sel_onehot);
    others_cur = |(live & ~cur_onehot);
  end

  // Target stepping. Arithmetic is one bit wider than the count so that
  // target+2 cannot wrap when the count equals MAX_TARGETS.
  assign cur_cnt = {1'b0, count_tab[out_port]};
  assign tgt_p1  = {2'b00, target} + (CNT_W+1)'(1);
  assign tgt_p2  = {2'b00, target} + (CNT_W+1)'(2);
  assign more    = (tgt_p1 < cur_cnt);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SELECT;
      SELECT:  state_nxt = sel_found ? EMIT : IDLE;
      EMIT:    if (fire && !more) state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  // Address table carries no reset; only the counts gate its use.
  always_ff @(posedge clk) begin
    if (reset_n && cfg_ok && cfg_addr_write) begin
      addr_tab[cfg_port][cfg_index] <= cfg_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) count_tab[i] <= '0;
      pending     <= '0;
      target      <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_dest    <= '0;
      out_port    <= '0;
      out_data    <= '0;
      out_lamport <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;

      if (cfg_any) begin
        if (cfg_ok) begin
          if (cfg_count_write) count_tab[cfg_port] <= cfg_count_clamped;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            pending     <= req_ports;
            out_data    <= req_data;
            out_lamport <= req_lamport;
          end
        end

        SELECT: begin
          pending <= pending & nz_mask;
          if (sel_found) begin
            out_dest  <= addr_tab[sel_port][0];
            out_port  <= sel_port;
            out_valid <= 1'b1;
            target    <= '0;
            out_last  <= (count_tab[sel_port] == CNT_W'(1)) && !others_sel;
          end else begin
            done <= 1'b1;
          end
        end

        EMIT: begin
          if (fire) begin
            if (more) begin
              target   <= tgt_p1[TGT_IDX_W-1:0];
              out_dest <= addr_tab[out_port][tgt_p1[TGT_IDX_W-1:0]];
              out_last <= (tgt_p2 >= cur_cnt) && !others_cur;
            end else begin
              pending   <= pending & ~cur_onehot;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_fanout_sequencer.sv
// Testbench for dircc_fanout_sequencer: table-driven beat sequences plus
// hand-written sequences for empty requests, count clamping, cfg writes while
// busy and reset in the middle of a send.
module tb_dircc_fanout_sequencer;

  localparam int NUM_PORTS = 8;
  localparam int MAX_TGT   = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_addr_write, cfg_count_write;
  logic [2:0]  cfg_port;
  logic [3:0]  cfg_index;
  logic [31:0] cfg_dest;
  logic [4:0]  cfg_count;
  logic        cfg_err;
  logic        req_valid, req_ready;
  logic [7:0]  req_ports;
  logic [63:0] req_data;
  logic [31:0] req_lamport;
  logic        out_valid, out_ready;
  logic [31:0] out_dest;
  logic [2:0]  out_port;
  logic [63:0] out_data;
  logic [31:0] out_lamport;
  logic        out_last, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  dircc_fanout_sequencer #(
    .NUM_PORTS(NUM_PORTS), .MAX_TARGETS(MAX_TGT),
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .LAMPORT_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_addr_write(cfg_addr_write), .cfg_count_write(cfg_count_write),
    .cfg_port(cfg_port), .cfg_index(cfg_index), .cfg_dest(cfg_dest),
    .cfg_count(cfg_count), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_ports(req_ports),
    .req_data(req_data), .req_lamport(req_lamport),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_port(out_port), .out_data(out_data), .out_lamport(out_lamport),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          start;
    logic [7:0]  ports;
    logic [63:0] payload;
    bit          rdy;
    bit          v;
    logic [2:0]  port;
    logic [31:0] dest;
    bit          last;
    bit          dn;
  } vec_t;

  function automatic logic [31:0] lam_of(input logic [63:0] d);
    return d[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input bit aw, input bit cw, input logic [2:0] p,
                           input logic [3:0] idx, input logic [31:0] d, input logic [4:0] c);
    cfg_addr_write  = aw;
    cfg_count_write = cw;
    cfg_port        = p;
    cfg_index       = idx;
    cfg_dest        = d;
    cfg_count       = c;
    tick();
    cfg_addr_write  = 1'b0;
    cfg_count_write = 1'b0;
  endtask

  // Presents a request in an idle cycle; returns in the SELECT cycle.
  task automatic send(input logic [7:0] ports, input logic [63:0] d);
    chk("req_ready before send", req_ready, 1'b1);
    req_valid   = 1'b1;
    req_ports   = ports;
    req_data    = d;
    req_lamport = lam_of(d);
    tick();
    req_valid   = 1'b0;
  endtask

  // Runs a request to completion with out_ready held high, checking that the
  // beat destinations are base, base+1, ... and that only the final one is last.
  task automatic drain(input int exp_n, input logic [31:0] base, input string nm);
    int beats = 0;
    bit seen  = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (out_valid) begin
        chk($sformatf("%s dest[%0d]", nm, beats), out_dest, 64'(base) + 64'(beats));
        chk($sformatf("%s last[%0d]", nm, beats), out_last, (beats == exp_n - 1));
        beats++;
      end
      if (done) seen = 1;
      else      tick();
    end
    chk({nm, " beat count"}, beats, exp_n);
    chk({nm, " done seen"}, seen, 1'b1);
  endtask

  vec_t vecs[24];
  logic [63:0] cur_data;
  int hs;

  initial begin
    // Each start row presents a request; every row checks one cycle.
    vecs[0]  = '{1, 8'h01, 64'h1111_2222_3333_4444, 1, 0, 0, 0,     0, 0};
    vecs[1]  = '{0, 0, 0,                           1, 1, 0, 32'h10, 0, 0};
    vecs[2]  = '{0, 0, 0,                           1, 1, 0, 32'h11, 0, 0};
    vecs[3]  = '{0, 0, 0,                           1, 1, 0, 32'h12, 1, 0};
    vecs[4]  = '{0, 0, 0,                           1, 0, 0, 0,     0, 0};
    vecs[5]  = '{0, 0, 0,                           1, 0, 0, 0,     0, 1};
    vecs[6]  = '{1, 8'h24, 64'hDEAD_BEEF_0BAD_F00D, 1, 0, 0, 0,     0, 0};
    vecs[7]  = '{0, 0, 0,                           1, 1, 2, 32'h20, 0, 0};
    vecs[8]  = '{0, 0, 0,                           1, 0, 0, 0,     0, 0};
    vecs[9]  = '{0, 0, 0,                           1, 1, 5, 32'h50, 0, 0};
    vecs[10] = '{0, 0, 0,                           1, 1, 5, 32'h51, 1, 0};
    vecs[11] = '{0, 0, 0,                           1, 0, 0, 0,     0, 0};
    vecs[12] = '{0, 0, 0,                           1, 0, 0, 0,     0, 1};
    vecs[13] = '{1, 8'h02, 64'hCAFE_0000_1234_5678, 0, 0, 0, 0,     0, 0};
    vecs[14] = '{0, 0, 0,                           0, 1, 1, 32'h30, 0, 0};
    vecs[15] = '{0, 0, 0,                           1, 1, 1, 32'h30, 0, 0};
    vecs[16] = '{0, 0, 0,                           0, 1, 1, 32'h31, 0, 0};
    vecs[17] = '{0, 0, 0,                           1, 1, 1, 32'h31, 0, 0};
    vecs[18] = '{0, 0, 0,                           0, 1, 1, 32'h32, 0, 0};
    vecs[19] = '{0, 0, 0,                           1, 1, 1, 32'h32, 0, 0};
    vecs[20] = '{0, 0, 0,                           0, 1, 1, 32'h33, 1, 0};
    vecs[21] = '{0, 0, 0,                           1, 1, 1, 32'h33, 1, 0};
    vecs[22] = '{0, 0, 0,                           1, 0, 0, 0,     0, 0};
    vecs[23] = '{0, 0, 0,                           1, 0, 0, 0,     0, 1};

    reset_n = 1'b0;
    cfg_addr_write = 0; cfg_count_write = 0; cfg_port = 0; cfg_index = 0;
    cfg_dest = 0; cfg_count = 0;
    req_valid = 0; req_ports = 0; req_data = 0; req_lamport = 0;
    out_ready = 0;
    cur_data  = 0;
    hs        = 0;
    repeat (3) tick();

    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_last", out_last, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset cfg_err", cfg_err, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset out_dest", out_dest, 0);
    chk("reset out_port", out_port, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_lamport", out_lamport, 0);
    reset_n = 1'b1;
    tick();

    // Table load. Port 2 uses a combined address+count write.
    cfg_write(0, 1, 3'd0, 0, 0, 5'd3);
    for (int i = 0; i < 3; i++) cfg_write(1, 0, 3'd0, 4'(i), 32'h10 + 32'(i), 0);
    cfg_write(1, 1, 3'd2, 4'd0, 32'h20, 5'd1);
    cfg_write(0, 1, 3'd5, 0, 0, 5'd2);
    cfg_write(1, 0, 3'd5, 4'd0, 32'h50, 0);
    cfg_write(1, 0, 3'd5, 4'd1, 32'h51, 0);
    cfg_write(0, 1, 3'd1, 0, 0, 5'd4);
    for (int i = 0; i < 4; i++) cfg_write(1, 0, 3'd1, 4'(i), 32'h30 + 32'(i), 0);
    cfg_write(0, 1, 3'd6, 0, 0, 5'd20);
    for (int i = 0; i < 16; i++) cfg_write(1, 0, 3'd6, 4'(i), 32'h60 + 32'(i), 0);
    chk("cfg_err after idle writes", cfg_err, 1'b0);

    for (int r = 0; r < 24; r++) begin
      if (vecs[r].start) begin
        cur_data = vecs[r].payload;
        send(vecs[r].ports, vecs[r].payload);
      end
      chk($sformatf("row%0d out_valid", r), out_valid, vecs[r].v);
      chk($sformatf("row%0d done", r), done, vecs[r].dn);
      if (vecs[r].dn) chk($sformatf("row%0d req_ready", r), req_ready, 1'b1);
      if (vecs[r].v) begin
        chk($sformatf("row%0d out_port", r), out_port, vecs[r].port);
        chk($sformatf("row%0d out_dest", r), out_dest, vecs[r].dest);
        chk($sformatf("row%0d out_last", r), out_last, vecs[r].last);
        chk($sformatf("row%0d out_data", r), out_data, cur_data);
        chk($sformatf("row%0d out_lamport", r), out_lamport, lam_of(cur_data));
      end
      out_ready = vecs[r].rdy;
      if (out_valid && out_ready) hs++;
      tick();
    end
    chk("table handshake total", hs, 10);

    // Empty requests: mask 0, then a port whose count is 0.
    out_ready = 1'b1;
    send(8'h00, 64'h5);
    chk("empty0 c1 valid", out_valid, 1'b0);
    chk("empty0 c1 done", done, 1'b0);
    tick();
    chk("empty0 c2 done", done, 1'b1);
    chk("empty0 c2 valid", out_valid, 1'b0);
    chk("empty0 c2 req_ready", req_ready, 1'b1);
    tick();
    chk("empty0 c3 done", done, 1'b0);
    send(8'h08, 64'h6);
    chk("empty3 c1 valid", out_valid, 1'b0);
    tick();
    chk("empty3 c2 done", done, 1'b1);
    chk("empty3 c2 valid", out_valid, 1'b0);
    tick();

    // Count 20 clamped to 16 targets.
    send(8'h40, 64'h0123_4567_89AB_CDEF);
    drain(16, 32'h60, "clamp");
    tick();

    // cfg write while busy is dropped and flagged.
    out_ready = 1'b0;
    send(8'h01, 64'h77);
    cfg_addr_write = 1'b1; cfg_count_write = 1'b1;
    cfg_port = 3'd0; cfg_index = 4'd0; cfg_dest = 32'hFF; cfg_count = 5'd1;
    tick();
    cfg_addr_write = 1'b0; cfg_count_write = 1'b0;
    chk("busy cfg_err pulse", cfg_err, 1'b1);
    tick();
    chk("busy cfg_err cleared", cfg_err, 1'b0);
    chk("busy held valid", out_valid, 1'b1);
    chk("busy held dest", out_dest, 32'h10);
    drain(3, 32'h10, "after busy cfg");
    tick();

    // Reset in the middle of EMIT abandons the request and clears counts.
    out_ready = 1'b0;
    send(8'h01, 64'h99);
    tick();
    chk("pre-reset valid", out_valid, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("post-reset valid", out_valid, 1'b0);
    chk("post-reset busy", busy, 1'b0);
    chk("post-reset done", done, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post-reset idle done c%0d", k), done, 1'b0);
      chk($sformatf("post-reset idle valid c%0d", k), out_valid, 1'b0);
    end
    send(8'h01, 64'hAA);
    chk("zero-count c1 valid", out_valid, 1'b0);
    tick();
    chk("zero-count c2 done", done, 1'b1);
    chk("zero-count c2 valid", out_valid, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
